// File: rtl/miner_pkg.sv
// Shared mining-datapath definitions: fetch FSM states, block geometry and RAM
// address width used by block_fetch and mem_manager.
package miner_pkg;

  localparam int ADDR_W        = 28;
  localparam int WORD_W        = 32;
  localparam int NUM_WORDS_DEF = 24;
  localparam int TIMEOUT_DEF   = 255;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_HOLD
  } fetch_state_t;

  // Byte address of a block word; the 28-bit space wraps silently.
  function automatic addr_t word_addr(input addr_t base, input int unsigned index);
    return base + addr_t'(index << 2);
  endfunction

endpackage

// File: rtl/block_regfile.sv
// Word store for one mining block: indexed single-word writes, the whole
// block presented flat with word 0 in the most significant bits.
module block_regfile
  import miner_pkg::*;
#(
  parameter int NUM_WORDS = NUM_WORDS_DEF,
  parameter int IDX_W     = $clog2(NUM_WORDS + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [IDX_W-1:0]            wr_index,
  input  word_t                       wr_data,
  output logic [WORD_W*NUM_WORDS-1:0] data
);

  word_t words [NUM_WORDS];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        words[i] <= '0;
      end
    end else if (wr_en && (int'(wr_index) < NUM_WORDS)) begin
      words[wr_index] <= wr_data;
    end
  end

  for (genvar g = 0; g < NUM_WORDS; g++) begin : g_flat
    assign data[WORD_W*(NUM_WORDS-g)-1 -: WORD_W] = words[g];
  end

endmodule

// File: rtl/block_fetch.sv
// Fetches one mining block word by word from the RAM master with a single
// outstanding read, a per-word timeout and a hold-until-accepted handoff.
module block_fetch
  import miner_pkg::*;
#(
  parameter int NUM_WORDS = NUM_WORDS_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           base_addr,
  output logic                        rd_go,
  output logic [ADDR_W-1:0]           rd_addr,
  input  logic                        rd_data_avail,
  input  logic [WORD_W-1:0]           rd_data,
  output logic [WORD_W*NUM_WORDS-1:0] block_data,
  output logic                        block_valid,
  input  logic                        block_ready,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int IDX_W  = $clog2(NUM_WORDS + 1);
  localparam int TCNT_W = $clog2(TIMEOUT + 1);

  fetch_state_t      state;
  logic [IDX_W-1:0]  index;
  logic [TCNT_W-1:0] tcount;
  addr_t             base_q;
  logic              last_word;
  logic              word_wr;

  assign last_word = (index == IDX_W'(NUM_WORDS - 1));
  assign word_wr   = (state == ST_WAIT) && rd_data_avail;

  // Returned data wins over a timeout landing in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      index       <= '0;
      tcount      <= '0;
      base_q      <= '0;
      rd_go       <= 1'b0;
      rd_addr     <= '0;
      block_valid <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      rd_go       <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            base_q  <= base_addr;
            index   <= '0;
            tcount  <= '0;
            rd_go   <= 1'b1;
            rd_addr <= word_addr(base_addr, 32'd0);
            busy    <= 1'b1;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (rd_data_avail) begin
            tcount <= '0;
            index  <= index + IDX_W'(1);
            if (last_word) begin
              block_valid <= 1'b1;
              state       <= ST_HOLD;
            end else begin
              rd_go   <= 1'b1;
              rd_addr <= word_addr(base_q, 32'(index) + 32'd1);
              state   <= ST_ISSUE;
            end
          end else if (tcount == TCNT_W'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            tcount <= tcount + TCNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (block_ready) begin
            block_valid <= 1'b0;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  block_regfile #(
    .NUM_WORDS(NUM_WORDS),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (word_wr),
    .wr_index(index),
    .wr_data (rd_data),
    .data    (block_data)
  );

endmodule

// File: doc/block_fetch.md
BLOCK_FETCH -- requirements
Module: block_fetch

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 24, meaning 32-bit words per mining block (96 bytes).
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning maximum WAIT cycles per word before abort.
REQ-003 SHALL have port clk  input  1  rising-edge system clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  single-cycle request to fetch one block.
REQ-006 SHALL have port base_addr  input  28  byte address of word 0, sampled on accepted start.
REQ-007 SHALL have port rd_go  output  1  single-cycle read request to the RAM master.
REQ-008 SHALL have port rd_addr  output  28  read byte address, valid while rd_go=1.
REQ-009 SHALL have port rd_data_avail  input  1  RAM master strobe: rd_data valid this cycle.
REQ-010 SHALL have port rd_data  input  32  read word from the RAM master.
REQ-011 SHALL have port block_data  output  32*NUM_WORDS  assembled block; word 0 in the most significant 32 bits.
REQ-012 SHALL have port block_valid  output  1  block_data complete and stable.
REQ-013 SHALL have port block_ready  input  1  downstream hasher accepts the block.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port timeout_err  output  1  single-cycle pulse on read timeout.

Function
REQ-016 SHALL implement states IDLE, ISSUE, WAIT and HOLD.
REQ-017 IDLE: on start=1, SHALL latch base_addr, clear the word index to 0, clear the timeout counter and go to ISSUE; start SHALL be ignored in every other state.
REQ-018 ISSUE: SHALL drive rd_go=1 for exactly one cycle with rd_addr = latched base + 4*index, modulo 2^28 (wrap, no error), then go to WAIT.
REQ-019 WAIT: on rd_data_avail=1, SHALL store rd_data at word position index, clear the timeout counter and increment index.
REQ-020 WAIT: if the stored word is index NUM_WORDS-1, SHALL go to HOLD; otherwise SHALL go to ISSUE.
REQ-021 WAIT: without rd_data_avail, SHALL increment the timeout counter.
REQ-022 WAIT: when the timeout counter reaches TIMEOUT, SHALL pulse timeout_err for one cycle and go to IDLE without asserting block_valid.
REQ-023 rd_data_avail outside WAIT SHALL be ignored; block_data SHALL not change.
REQ-024 HOLD: SHALL hold block_valid=1 with block_data stable until block_ready=1, then go to IDLE next cycle.
REQ-025 block_ready outside HOLD SHALL have no effect.
REQ-026 Latency, zero-wait RAM master (avail one cycle after rd_go): block_valid SHALL rise 2*NUM_WORDS+1 cycles after the accepted start.
REQ-027 rd_go SHALL never assert twice without an intervening rd_data_avail or timeout; at most one read is outstanding.
REQ-028 block_data SHALL retain its last contents in IDLE and SHALL be overwritten word by word on the next fetch.

Reset
REQ-029 reset=0 on a clock edge SHALL force IDLE, index=0, timeout counter=0, rd_go=0, rd_addr=0, block_valid=0, busy=0, timeout_err=0 and block_data=0.
REQ-030 Reset during ISSUE, WAIT or HOLD SHALL abort the fetch with no timeout_err pulse; a pending rd_data_avail arriving after reset SHALL be ignored.

Structure
REQ-031 The state enum, NUM_WORDS default, TIMEOUT default and the 28-bit address width SHALL live in the shared package miner_pkg, also used by mem_manager.
REQ-032 The word-store register array with indexed write SHALL be one sub-module, block_regfile; all other logic SHALL be in block_fetch.

Verification
REQ-033 Zero-wait master, start with base 0x8000008, words 0x00000001..0x00000018 -> rd_addr 0x8000008..0x8000064 step 4; block_valid at cycle 49; top word 0x00000001, bottom word 0x00000018.
REQ-034 Master with 3-cycle avail delay, block_ready held low 10 cycles after valid -> block_valid and block_data stable 10 cycles; IDLE one cycle after ready; busy low.
REQ-035 No rd_data_avail after the 5th rd_go -> timeout_err pulses once 255 cycles later; IDLE; block_valid never high.
REQ-036 base 0xFFFFFFC -> second rd_addr 0x0000000 (wrap); fetch completes normally.
REQ-037 start pulses during WAIT, plus a spurious rd_data_avail in HOLD -> both ignored; only one fetch runs; block_data unchanged in HOLD.
REQ-038 reset low at word 10 in WAIT, then avail arrives -> all outputs at reset values; next start fetches a full correct block.
